// File: rtl/dma_packer_controller.sv
// dma_packer_controller
// Moves a programmed number of narrow stream beats to or from a wide word
// memory. RATIO = MEM_W/STREAM_W beats are packed per word, beat 0 in the
// low lane. Handles partial last words, abort, and stream back-pressure.
// Every output is driven straight from a flop.
module dma_packer_controller #(
  parameter int STREAM_W = 8,
  parameter int MEM_W    = 16,
  parameter int ADDR_W   = 25,
  parameter int LEN_W    = 26
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Start,
  input  logic                Direction,
  input  logic                Abort,
  input  logic [ADDR_W-1:0]   Base_Addr,
  input  logic [LEN_W-1:0]    Length,
  output logic                Busy,
  output logic                Done,
  output logic [LEN_W-1:0]    Count,
  input  logic [STREAM_W-1:0] st_in_Data,
  input  logic                st_in_Valid,
  output logic                st_in_Ready,
  output logic [STREAM_W-1:0] st_out_Data,
  output logic                st_out_Valid,
  input  logic                st_out_Ready,
  output logic [ADDR_W-1:0]   mem_Addr,
  output logic [MEM_W-1:0]    mem_Din,
  output logic                mem_Req,
  output logic                mem_WE,
  input  logic [MEM_W-1:0]    mem_Dout,
  input  logic                mem_Ack
);

  localparam int RATIO = MEM_W / STREAM_W;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FILL   = 3'd1;
  localparam logic [2:0] S_WRITE  = 3'd2;
  localparam logic [2:0] S_READ   = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;

  // Control and datapath state
  logic [2:0]          state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    count_q, count_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [MEM_W-1:0]    lane_q, lane_d;
  logic                abort_pend_q, abort_pend_d;

  // Registered outputs
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic                st_in_ready_q, st_in_ready_d;
  logic                st_out_valid_q, st_out_valid_d;
  logic [STREAM_W-1:0] st_out_data_q, st_out_data_d;
  logic [MEM_W-1:0]    mem_din_q, mem_din_d;

  logic [LEN_W-1:0]    count_inc_s;

  // Pick lane idx out of a packed word; out-of-range indices read as zero.
  function automatic logic [STREAM_W-1:0] lane_get(input logic [MEM_W-1:0] word,
                                                   input logic [IDX_W-1:0] idx);
    logic [STREAM_W-1:0] r;
    r = '0;
    for (int i = 0; i < RATIO; i++) begin
      r = (idx == IDX_W'(i)) ? word[i*STREAM_W +: STREAM_W] : r;
    end
    return r;
  endfunction

  // Replace lane idx of a packed word with beat, leaving other lanes intact.
  function automatic logic [MEM_W-1:0] lane_put(input logic [MEM_W-1:0]    word,
                                                input logic [IDX_W-1:0]    idx,
                                                input logic [STREAM_W-1:0] beat);
    logic [MEM_W-1:0] r;
    r = word;
    for (int i = 0; i < RATIO; i++) begin
      r[i*STREAM_W +: STREAM_W] = (idx == IDX_W'(i)) ? beat : r[i*STREAM_W +: STREAM_W];
    end
    return r;
  endfunction

  assign count_inc_s = count_q + LEN_W'(1);

  // Next-state logic for the transfer FSM and its datapath registers
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    len_d        = len_q;
    count_d      = count_q;
    idx_d        = idx_q;
    lane_d       = lane_q;
    abort_pend_d = abort_pend_q;

    case (state_q)
      S_IDLE: begin
        // Abort is meaningless here, so a simultaneous Start simply wins.
        if (Start) begin
          addr_d       = Base_Addr;
          len_d        = Length;
          count_d      = '0;
          idx_d        = '0;
          lane_d       = '0;
          abort_pend_d = 1'b0;
          if (Length == '0) begin
            state_d = S_FINISH;
          end else if (Direction) begin
            state_d = S_READ;
          end else begin
            state_d = S_FILL;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_FILL: begin
        if (st_in_Valid && st_in_ready_q) begin
          // An accepted beat is always counted, even alongside Abort.
          lane_d  = lane_put(lane_q, idx_q, st_in_Data);
          count_d = count_inc_s;
          if ((count_inc_s == len_q) || (idx_q == LAST_IDX)) begin
            // A completed word is still written; a pending abort ends
            // the transfer once the write is acknowledged.
            state_d      = S_WRITE;
            idx_d        = '0;
            abort_pend_d = Abort;
          end else if (Abort) begin
            state_d = S_FINISH;
            lane_d  = '0;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else if (Abort) begin
          // Partial word is discarded.
          state_d = S_FINISH;
          lane_d  = '0;
          idx_d   = '0;
        end else begin
          state_d = S_FILL;
        end
      end

      S_WRITE: begin
        abort_pend_d = abort_pend_q | Abort;
        if (mem_Ack) begin
          addr_d       = addr_q + ADDR_W'(1);
          lane_d       = '0;
          idx_d        = '0;
          abort_pend_d = 1'b0;
          if ((count_q == len_q) || abort_pend_q || Abort) begin
            state_d = S_FINISH;
          end else begin
            state_d = S_FILL;
          end
        end else begin
          state_d = S_WRITE;
        end
      end

      S_READ: begin
        abort_pend_d = abort_pend_q | Abort;
        if (mem_Ack) begin
          idx_d        = '0;
          abort_pend_d = 1'b0;
          if (abort_pend_q || Abort) begin
            state_d = S_FINISH;
            lane_d  = '0;
          end else begin
            state_d = S_DRAIN;
            lane_d  = mem_Dout;
          end
        end else begin
          state_d = S_READ;
        end
      end

      S_DRAIN: begin
        if (st_out_valid_q && st_out_Ready) begin
          count_d = count_inc_s;
          if ((count_inc_s == len_q) || Abort) begin
            state_d = S_FINISH;
            idx_d   = '0;
          end else if (idx_q == LAST_IDX) begin
            state_d = S_READ;
            addr_d  = addr_q + ADDR_W'(1);
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else if (Abort) begin
          state_d = S_FINISH;
          idx_d   = '0;
        end else begin
          state_d = S_DRAIN;
        end
      end

      S_FINISH: begin
        state_d      = S_IDLE;
        abort_pend_d = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output register inputs, derived from the state being entered
  always_comb begin
    busy_d         = (state_d == S_FILL) || (state_d == S_WRITE) ||
                     (state_d == S_READ) || (state_d == S_DRAIN);
    done_d         = (state_q == S_FINISH);
    mem_req_d      = (state_d == S_WRITE) || (state_d == S_READ);
    mem_we_d       = (state_d == S_WRITE);
    st_in_ready_d  = (state_d == S_FILL);
    st_out_valid_d = (state_d == S_DRAIN);

    // Write data is captured once on entry and held until acknowledged.
    if ((state_d == S_WRITE) && (state_q != S_WRITE)) begin
      mem_din_d = lane_d;
    end else begin
      mem_din_d = mem_din_q;
    end

    // Outbound beat follows the lane pointer; stable while stalled.
    if (state_d == S_DRAIN) begin
      st_out_data_d = lane_get(lane_d, idx_d);
    end else begin
      st_out_data_d = st_out_data_q;
    end
  end

  // State and output flops with asynchronous reset
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q        <= S_IDLE;
      addr_q         <= '0;
      len_q          <= '0;
      count_q        <= '0;
      idx_q          <= '0;
      lane_q         <= '0;
      abort_pend_q   <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      st_in_ready_q  <= 1'b0;
      st_out_valid_q <= 1'b0;
      st_out_data_q  <= '0;
      mem_din_q      <= '0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      len_q          <= len_d;
      count_q        <= count_d;
      idx_q          <= idx_d;
      lane_q         <= lane_d;
      abort_pend_q   <= abort_pend_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      mem_req_q      <= mem_req_d;
      mem_we_q       <= mem_we_d;
      st_in_ready_q  <= st_in_ready_d;
      st_out_valid_q <= st_out_valid_d;
      st_out_data_q  <= st_out_data_d;
      mem_din_q      <= mem_din_d;
    end
  end

  assign Busy         = busy_q;
  assign Done         = done_q;
  assign Count        = count_q;
  assign st_in_Ready  = st_in_ready_q;
  assign st_out_Data  = st_out_data_q;
  assign st_out_Valid = st_out_valid_q;
  assign mem_Addr     = addr_q;
  assign mem_Din      = mem_din_q;
  assign mem_Req      = mem_req_q;
  assign mem_WE       = mem_we_q;

endmodule

// File: tb/tb_dma_packer_controller.sv
// Directed bench for dma_packer_controller: a 16-bit-word instance (a_*)
// and a 32-bit-word instance (b_*), sharing clock and reset.
module tb_dma_packer_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: MEM_W = 16
  logic        a_start = 1'b0, a_dir = 1'b0, a_abort = 1'b0;
  logic [24:0] a_base = '0;
  logic [25:0] a_len = '0;
  logic        a_busy, a_done;
  logic [25:0] a_count;
  logic [7:0]  a_in_data = '0;
  logic        a_in_valid = 1'b0, a_in_ready;
  logic [7:0]  a_out_data;
  logic        a_out_valid, a_out_ready = 1'b0;
  logic [24:0] a_addr;
  logic [15:0] a_din;
  logic        a_req, a_we;
  logic [15:0] a_dout = '0;
  logic        a_mem_ack = 1'b0;

  // Instance B: MEM_W = 32
  logic        b_start = 1'b0, b_dir = 1'b0, b_abort = 1'b0;
  logic [24:0] b_base = '0;
  logic [25:0] b_len = '0;
  logic        b_busy, b_done;
  logic [25:0] b_count;
  logic [7:0]  b_in_data = '0;
  logic        b_in_valid = 1'b0, b_in_ready;
  logic [7:0]  b_out_data;
  logic        b_out_valid, b_out_ready = 1'b0;
  logic [24:0] b_addr;
  logic [31:0] b_din;
  logic        b_req, b_we;
  logic [31:0] b_dout = '0;
  logic        b_mem_ack = 1'b0;

  dma_packer_controller #(.STREAM_W(8), .MEM_W(16), .ADDR_W(25), .LEN_W(26)) u_dut_a (
    .Clk(clk), .Reset(rst), .Start(a_start), .Direction(a_dir), .Abort(a_abort),
    .Base_Addr(a_base), .Length(a_len), .Busy(a_busy), .Done(a_done), .Count(a_count),
    .st_in_Data(a_in_data), .st_in_Valid(a_in_valid), .st_in_Ready(a_in_ready),
    .st_out_Data(a_out_data), .st_out_Valid(a_out_valid), .st_out_Ready(a_out_ready),
    .mem_Addr(a_addr), .mem_Din(a_din), .mem_Req(a_req), .mem_WE(a_we),
    .mem_Dout(a_dout), .mem_Ack(a_mem_ack));

  dma_packer_controller #(.STREAM_W(8), .MEM_W(32), .ADDR_W(25), .LEN_W(26)) u_dut_b (
    .Clk(clk), .Reset(rst), .Start(b_start), .Direction(b_dir), .Abort(b_abort),
    .Base_Addr(b_base), .Length(b_len), .Busy(b_busy), .Done(b_done), .Count(b_count),
    .st_in_Data(b_in_data), .st_in_Valid(b_in_valid), .st_in_Ready(b_in_ready),
    .st_out_Data(b_out_data), .st_out_Valid(b_out_valid), .st_out_Ready(b_out_ready),
    .mem_Addr(b_addr), .mem_Din(b_din), .mem_Req(b_req), .mem_WE(b_we),
    .mem_Dout(b_dout), .mem_Ack(b_mem_ack));

  int n_checks = 0;
  int n_pass   = 0;
  int a_done_n = 0, b_done_n = 0, a_req_n = 0, b_req_n = 0;
  logic a_req_prev = 1'b0, b_req_prev = 1'b0;

  // Advance to the next falling edge and tally Done pulses and new requests.
  task automatic step();
    @(negedge clk);
    if (a_done) a_done_n++;
    if (b_done) b_done_n++;
    if (a_req && !a_req_prev) a_req_n++;
    if (b_req && !b_req_prev) b_req_n++;
    a_req_prev = a_req;
    b_req_prev = b_req;
  endtask

  task automatic a_go(input logic dir, input logic [24:0] base, input logic [25:0] len);
    a_dir = dir; a_base = base; a_len = len; a_start = 1'b1;
    step();
    a_start = 1'b0;
  endtask

  task automatic a_send(input logic [7:0] d);
    for (int i = 0; i < 40 && !a_in_ready; i++) step();
    a_in_data = d; a_in_valid = 1'b1;
    step();
    a_in_valid = 1'b0;
  endtask

  task automatic a_wait_req();
    for (int i = 0; i < 40 && !a_req; i++) step();
  endtask

  task automatic a_ack_pulse(input logic [15:0] d);
    a_dout = d; a_mem_ack = 1'b1;
    step();
    a_mem_ack = 1'b0;
  endtask

  task automatic a_wait_out();
    for (int i = 0; i < 40 && !a_out_valid; i++) step();
  endtask

  task automatic a_take();
    a_out_ready = 1'b1;
    step();
    a_out_ready = 1'b0;
  endtask

  task automatic b_go(input logic dir, input logic [24:0] base, input logic [25:0] len);
    b_dir = dir; b_base = base; b_len = len; b_start = 1'b1;
    step();
    b_start = 1'b0;
  endtask

  task automatic b_send(input logic [7:0] d);
    for (int i = 0; i < 40 && !b_in_ready; i++) step();
    b_in_data = d; b_in_valid = 1'b1;
    step();
    b_in_valid = 1'b0;
  endtask

  task automatic b_wait_req();
    for (int i = 0; i < 40 && !b_req; i++) step();
  endtask

  task automatic b_ack_pulse(input logic [31:0] d);
    b_dout = d; b_mem_ack = 1'b1;
    step();
    b_mem_ack = 1'b0;
  endtask

  task automatic b_wait_out();
    for (int i = 0; i < 40 && !b_out_valid; i++) step();
  endtask

  task automatic b_take();
    b_out_ready = 1'b1;
    step();
    b_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    n_checks++; if ({a_busy, a_done, a_req, a_we, a_in_ready, a_out_valid} !== 6'b0) $display("FAIL rst_ctrl got=%b exp=000000", {a_busy, a_done, a_req, a_we, a_in_ready, a_out_valid}); else n_pass++;
    n_checks++; if ({a_count, a_addr, a_din, a_out_data} !== 75'd0) $display("FAIL rst_data got=%h exp=0", {a_count, a_addr, a_din, a_out_data}); else n_pass++;
    rst = 1'b0;
    step();
    n_checks++; if ({a_busy, a_req, b_busy, b_req} !== 4'b0) $display("FAIL rst_idle got=%b exp=0000", {a_busy, a_req, b_busy, b_req}); else n_pass++;
  endtask

  task automatic test_write_basic();
    a_done_n = 0;
    a_go(1'b0, 25'h10, 26'd4);
    n_checks++; if (a_busy !== 1'b1) $display("FAIL wr_busy got=%b exp=1", a_busy); else n_pass++;
    a_send(8'h11); a_send(8'h22);
    a_wait_req();
    n_checks++; if ({a_req, a_we} !== 2'b11) $display("FAIL wr0_reqwe got=%b exp=11", {a_req, a_we}); else n_pass++;
    n_checks++; if (a_addr !== 25'h10) $display("FAIL wr0_addr got=%h exp=%h", a_addr, 25'h10); else n_pass++;
    n_checks++; if (a_din !== 16'h2211) $display("FAIL wr0_din got=%h exp=%h", a_din, 16'h2211); else n_pass++;
    step();
    n_checks++; if ({a_req, a_we, a_din, a_addr} !== {2'b11, 16'h2211, 25'h10}) $display("FAIL wr0_hold got=%b/%h/%h", {a_req, a_we}, a_din, a_addr); else n_pass++;
    a_ack_pulse(16'h0000);
    a_send(8'h33); a_send(8'h44);
    a_wait_req();
    n_checks++; if ({a_req, a_we, a_din, a_addr} !== {2'b11, 16'h4433, 25'h11}) $display("FAIL wr1 got=%b din=%h addr=%h exp=11 4433 11", {a_req, a_we}, a_din, a_addr); else n_pass++;
    a_ack_pulse(16'h0000);
    for (int i = 0; i < 4; i++) step();
    n_checks++; if (a_count !== 26'd4) $display("FAIL wr_count got=%0d exp=4", a_count); else n_pass++;
    n_checks++; if (a_done_n !== 1) $display("FAIL wr_done_pulses got=%0d exp=1", a_done_n); else n_pass++;
    n_checks++; if (a_busy !== 1'b0) $display("FAIL wr_busy_end got=%b exp=0", a_busy); else n_pass++;
  endtask

  task automatic test_partial_wrap();
    a_done_n = 0;
    a_go(1'b0, 25'h1FFFFFF, 26'd3);
    a_send(8'hAA); a_send(8'hBB);
    a_wait_req();
    n_checks++; if ({a_req, a_we, a_din, a_addr} !== {2'b11, 16'hBBAA, 25'h1FFFFFF}) $display("FAIL wrap0 got=%b din=%h addr=%h exp=11 bbaa 1ffffff", {a_req, a_we}, a_din, a_addr); else n_pass++;
    a_ack_pulse(16'h0000);
    a_send(8'hCC);
    a_wait_req();
    n_checks++; if ({a_req, a_we, a_din, a_addr} !== {2'b11, 16'h00CC, 25'h0}) $display("FAIL wrap1 got=%b din=%h addr=%h exp=11 00cc 0", {a_req, a_we}, a_din, a_addr); else n_pass++;
    a_ack_pulse(16'h0000);
    for (int i = 0; i < 4; i++) step();
    n_checks++; if ({a_count, a_done_n[3:0]} !== {26'd3, 4'd1}) $display("FAIL wrap_end count=%0d done=%0d exp=3 1", a_count, a_done_n); else n_pass++;
  endtask

  task automatic test_read_backpressure();
    a_done_n = 0; a_req_n = 0;
    a_go(1'b1, 25'h20, 26'd3);
    a_wait_req();
    n_checks++; if ({a_req, a_we, a_addr} !== {2'b10, 25'h20}) $display("FAIL rd0 got=%b addr=%h exp=10 20", {a_req, a_we}, a_addr); else n_pass++;
    a_ack_pulse(16'h2211);
    a_wait_out();
    n_checks++; if ({a_out_valid, a_out_data} !== {1'b1, 8'h11}) $display("FAIL rd_beat0 got=%b/%h exp=1/11", a_out_valid, a_out_data); else n_pass++;
    a_take();
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++; if ({a_out_valid, a_out_data} !== {1'b1, 8'h22}) $display("FAIL rd_stall%0d got=%b/%h exp=1/22", k, a_out_valid, a_out_data); else n_pass++;
    end
    a_take();
    a_wait_req();
    n_checks++; if ({a_req, a_we, a_addr} !== {2'b10, 25'h21}) $display("FAIL rd1 got=%b addr=%h exp=10 21", {a_req, a_we}, a_addr); else n_pass++;
    a_ack_pulse(16'h4433);
    a_wait_out();
    n_checks++; if ({a_out_valid, a_out_data} !== {1'b1, 8'h33}) $display("FAIL rd_beat2 got=%b/%h exp=1/33", a_out_valid, a_out_data); else n_pass++;
    a_take();
    for (int i = 0; i < 5; i++) step();
    n_checks++; if (a_req_n !== 2) $display("FAIL rd_reads got=%0d exp=2", a_req_n); else n_pass++;
    n_checks++; if ({a_count, a_out_valid, a_done_n[3:0]} !== {26'd3, 1'b0, 4'd1}) $display("FAIL rd_end count=%0d valid=%b done=%0d exp=3 0 1", a_count, a_out_valid, a_done_n); else n_pass++;
  endtask

  task automatic test_zero_len_and_restart();
    a_done_n = 0; a_req_n = 0;
    a_go(1'b0, 25'h55, 26'd0);
    n_checks++; if ({a_done, a_busy} !== 2'b00) $display("FAIL z_c1 done/busy got=%b exp=00", {a_done, a_busy}); else n_pass++;
    step();
    n_checks++; if ({a_done, a_busy} !== 2'b10) $display("FAIL z_c2 done/busy got=%b exp=10", {a_done, a_busy}); else n_pass++;
    step(); step();
    n_checks++; if ({a_req_n[3:0], a_done_n[3:0]} !== {4'd0, 4'd1}) $display("FAIL z_end reqs=%0d dones=%0d exp=0 1", a_req_n, a_done_n); else n_pass++;
    // Second Start mid-transfer must not take effect.
    a_done_n = 0;
    a_go(1'b0, 25'h40, 26'd2);
    a_send(8'h5A);
    a_go(1'b1, 25'h77, 26'd5);
    a_send(8'hA5);
    a_wait_req();
    n_checks++; if ({a_req, a_we, a_din, a_addr} !== {2'b11, 16'hA55A, 25'h40}) $display("FAIL ign_wr got=%b din=%h addr=%h exp=11 a55a 40", {a_req, a_we}, a_din, a_addr); else n_pass++;
    a_ack_pulse(16'h0000);
    for (int i = 0; i < 5; i++) step();
    n_checks++; if ({a_count, a_done_n[3:0], a_busy} !== {26'd2, 4'd1, 1'b0}) $display("FAIL ign_end count=%0d done=%0d busy=%b exp=2 1 0", a_count, a_done_n, a_busy); else n_pass++;
  endtask

  task automatic test_reset_mid_write();
    a_done_n = 0;
    a_go(1'b0, 25'h30, 26'd2);
    a_send(8'h01); a_send(8'h02);
    a_wait_req();
    n_checks++; if (a_req !== 1'b1) $display("FAIL mrst_pre got=%b exp=1", a_req); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++; if ({a_req, a_busy, a_count} !== {2'b00, 26'd0}) $display("FAIL mrst_now req=%b busy=%b count=%0d exp=0 0 0", a_req, a_busy, a_count); else n_pass++;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step();
    n_checks++; if ({a_req, a_in_ready, a_busy, a_done_n[3:0]} !== 7'b0) $display("FAIL mrst_idle req=%b rdy=%b busy=%b dones=%0d exp=all 0", a_req, a_in_ready, a_busy, a_done_n); else n_pass++;
  endtask

  task automatic test_wide_and_abort();
    b_done_n = 0; b_req_n = 0;
    b_go(1'b0, 25'h100, 26'd4);
    b_send(8'h01); b_send(8'h02); b_send(8'h03); b_send(8'h04);
    b_wait_req();
    n_checks++; if ({b_req, b_we, b_din, b_addr} !== {2'b11, 32'h04030201, 25'h100}) $display("FAIL w32 got=%b din=%h addr=%h exp=11 04030201 100", {b_req, b_we}, b_din, b_addr); else n_pass++;
    b_ack_pulse(32'h0);
    for (int i = 0; i < 4; i++) step();
    n_checks++; if ({b_req_n[3:0], b_done_n[3:0], b_count} !== {4'd1, 4'd1, 26'd4}) $display("FAIL w32_end writes=%0d dones=%0d count=%0d exp=1 1 4", b_req_n, b_done_n, b_count); else n_pass++;
    b_done_n = 0; b_req_n = 0;
    b_go(1'b1, 25'h200, 26'd8);
    b_wait_req();
    b_ack_pulse(32'h44332211);
    b_wait_out();
    n_checks++; if (b_out_data !== 8'h11) $display("FAIL ab_beat0 got=%h exp=11", b_out_data); else n_pass++;
    b_take();
    n_checks++; if (b_out_data !== 8'h22) $display("FAIL ab_beat1 got=%h exp=22", b_out_data); else n_pass++;
    b_take();
    b_abort = 1'b1;
    step();
    b_abort = 1'b0;
    for (int i = 0; i < 6; i++) step();
    n_checks++; if (b_count !== 26'd2) $display("FAIL ab_count got=%0d exp=2", b_count); else n_pass++;
    n_checks++; if ({b_req_n[3:0], b_done_n[3:0], b_req, b_out_valid} !== {4'd1, 4'd1, 2'b00}) $display("FAIL ab_end reads=%0d dones=%0d req=%b valid=%b exp=1 1 0 0", b_req_n, b_done_n, b_req, b_out_valid); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_partial_wrap();
    test_read_backpressure();
    test_zero_len_and_restart();
    test_reset_mid_write();
    test_wide_and_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
